mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between the CPU core and the UART boot loader.
//  After reset it runs in BOOT: only the loader is granted and the CPU is held stalled.
//  RUN is entered on boot_done; in RUN, simultaneous requests are arbitrated round-robin.
//  Read data is routed back to the requester that issued the read, RD_LAT cycles later.
// PARAMETERS
//  ADDR_W  8  RAM address width
//  DATA_W  8  RAM data width
//  RD_LAT  1  RAM read latency in cycles (mem_en -> mem_rdata); legal range 1..4
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  boot_done   in   1       loader pulse: image loaded, BOOT->RUN
//  boot_req    in   1       loader level: request re-entry to BOOT (RUN only)
//  cpu_run     out  1       1 = CPU may execute; 0 = CPU held stalled
//  cpu_req     in   1       CPU access request
//  cpu_we      in   1       CPU write enable
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       CPU access accepted this cycle
//  cpu_rvalid  out  1       CPU read data valid
//  cpu_rdata   out  DATA_W  CPU read data
//  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: loader port, same as cpu_*
//  mem_en      out  1       RAM access strobe
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data, valid RD_LAT cycles after mem_en & !mem_we
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state=BOOT, rr_last=LDR, tag pipeline cleared, cpu_run=0.
//   - All gnt and rvalid outputs are 0; mem_en=0 and mem_we=0. This holds while reset is low.
//  Handshake:
//   - A requester holds req/we/addr/wdata stable until it sees gnt.
//   - gnt is combinational in the same cycle; at most one gnt per cycle; the access completes on that edge.
//   - mem_* are a combinational mux of the granted port. mem_en = |gnt and mem_we = winner's we.
//   - With no grant, mem_addr/mem_wdata carry the loader port's values and mem_en=0.
//  Read return:
//   - Each granted read pushes {valid, id} into a RD_LAT-deep shift register.
//   - At the output, rvalid is asserted for one cycle on the owning port only.
//   - cpu_rdata and ldr_rdata are both driven from mem_rdata; they are meaningful only while the matching rvalid is high.
//   - Writes produce no rvalid.
//  FSM:
//   - BOOT: ldr_gnt=ldr_req; cpu_gnt=0; cpu_run=0. boot_done=1 -> RUN next cycle.
//     A loader access in the same cycle as boot_done is still granted. boot_req is ignored in BOOT.
//   - RUN: cpu_run=1.
//     Only one requester: it is granted. Both requesting: grant the port != rr_last.
//     rr_last updates to the granted port on every grant. boot_done is ignored.
//     boot_req=1 -> DRAIN next cycle; an access granted in that same cycle still completes.
//   - DRAIN: no grants; cpu_run=0. Reads already in flight still return their rvalid.
//     When the tag pipeline is empty -> BOOT next cycle; boot_req is not re-checked.
//   - Undefined state encodings recover to BOOT.
//  Boundaries:
//   - Reset asserted mid-read: the pending rvalid is dropped and never issued.
//   - Back-to-back reads from alternating ports: return order = issue order, one per cycle.
//   - A CPU request pending in BOOT/DRAIN waits with gnt=0; it is granted in the first RUN cycle.
// TESTING
//  1. Release reset; hold cpu_req=1 and ldr writes 0xA5 to addr 0x10.
//     -> ldr_gnt=1, mem_we=1, cpu_gnt=0, cpu_run=0 throughout.
//  2. Pulse boot_done; CPU reads 0x10 (RD_LAT=1).
//     -> cpu_run=1 next cycle; cpu_gnt=1; one cycle later cpu_rvalid=1, cpu_rdata=0xA5, ldr_rvalid=0.
//  3. In RUN, hold cpu_req and ldr_req for 4 cycles.
//     -> grants CPU, LDR, CPU, LDR (rr_last=LDR out of reset).
//  4. RD_LAT=3; CPU read of 0x10 then loader read of 0x11 back-to-back.
//     -> cpu_rvalid 3 cycles after its grant, ldr_rvalid the cycle after, data routed correctly.
//  5. RD_LAT=3; CPU read granted, then boot_req=1 the next cycle.
//     -> DRAIN, cpu_rvalid still fires, then BOOT; cpu_gnt=0 throughout DRAIN and BOOT.
//  6. Assert reset 1 cycle after a CPU read grant (RD_LAT=2).
//     -> no cpu_rvalid ever; state=BOOT and cpu_run=0 immediately.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, loader and RAM request/response signals shared by the arbiter.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port between CPU and boot loader, with BOOT/RUN/DRAIN control
// and round-robin arbitration; read data is routed back by a latency-matched tag pipeline.
module mem_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             boot_done_i,
  input  logic             boot_req_i,
  output logic             cpu_run_o,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [RD_LAT-1:0] vld_q, vld_d, id_q, id_d;
  logic              cpu_sel, ldr_sel, cpu_gnt, ldr_gnt, rd_push;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cpu_sel   = 1'b0;
    ldr_sel   = 1'b0;
    cpu_run_o = 1'b0;
    case (state_q)
      BOOT: begin
        ldr_sel = bus.ldr_req;
        state_d = boot_done_i ? RUN : BOOT;
      end
      RUN: begin
        cpu_run_o = 1'b1;
        // rr_last_q = 1 means the loader won last, so the CPU wins a tie
        cpu_sel   = bus.cpu_req & (~bus.ldr_req | rr_last_q);
        ldr_sel   = bus.ldr_req & ~cpu_sel;
        rr_last_d = (cpu_sel | ldr_sel) ? ldr_sel : rr_last_q;
        state_d   = boot_req_i ? DRAIN : RUN;
      end
      DRAIN: state_d = (|vld_q) ? DRAIN : BOOT;
      default: state_d = BOOT;
    endcase
  end
  // grants are masked while reset is held so nothing reaches the RAM
  assign cpu_gnt = cpu_sel & rst_ni;
  assign ldr_gnt = ldr_sel & rst_ni;
  assign addr    = cpu_gnt ? bus.cpu_addr : bus.ldr_addr;
  assign wdata   = cpu_gnt ? bus.cpu_wdata : bus.ldr_wdata;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.ldr_gnt   = ldr_gnt;
  assign bus.mem_en    = cpu_gnt | ldr_gnt;
  assign bus.mem_we    = cpu_gnt ? bus.cpu_we : (ldr_gnt & bus.ldr_we);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign rd_push = bus.mem_en & ~bus.mem_we;
  assign vld_d   = (vld_q << 1) | RD_LAT'(rd_push);
  assign id_d    = (id_q << 1) | RD_LAT'(ldr_gnt);
  assign bus.cpu_rvalid = vld_q[RD_LAT-1] & ~id_q[RD_LAT-1];
  assign bus.ldr_rvalid = vld_q[RD_LAT-1] & id_q[RD_LAT-1];
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ldr_rdata  = bus.mem_rdata;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BOOT;
      rr_last_q <= 1'b1;
      vld_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vectors against three arbiters (RD_LAT 1, 2, 3) fed identical stimulus.
module tb_mem_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, bd, br, c_req, c_we, l_req, l_we;
  logic [7:0] c_addr, c_wd, l_addr, l_wd;
  logic       run1, run2, run3;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b2 ();
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b3 ();
  assign {b1.cpu_req, b1.cpu_we, b1.cpu_addr, b1.cpu_wdata, b1.ldr_req, b1.ldr_we, b1.ldr_addr, b1.ldr_wdata} =
         {c_req, c_we, c_addr, c_wd, l_req, l_we, l_addr, l_wd};
  assign {b2.cpu_req, b2.cpu_we, b2.cpu_addr, b2.cpu_wdata, b2.ldr_req, b2.ldr_we, b2.ldr_addr, b2.ldr_wdata} =
         {c_req, c_we, c_addr, c_wd, l_req, l_we, l_addr, l_wd};
  assign {b3.cpu_req, b3.cpu_we, b3.cpu_addr, b3.cpu_wdata, b3.ldr_req, b3.ldr_we, b3.ldr_addr, b3.ldr_wdata} =
         {c_req, c_we, c_addr, c_wd, l_req, l_we, l_addr, l_wd};

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .boot_done_i(bd),
    .boot_req_i(br), .cpu_run_o(run1), .bus(b1.slave));
  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .boot_done_i(bd),
    .boot_req_i(br), .cpu_run_o(run2), .bus(b2.slave));
  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u3 (.clk_i(clk), .rst_ni(rst_n), .boot_done_i(bd),
    .boot_req_i(br), .cpu_run_o(run3), .bus(b3.slave));

  // one RAM model per arbiter; read data tapped at the stage matching its RD_LAT
  logic       m_en [3], m_we [3];
  logic [7:0] m_ad [3], m_wd [3];
  logic [7:0] ram  [3][256];
  logic [7:0] pip  [3][4];
  assign {m_en[0], m_we[0], m_ad[0], m_wd[0]} = {b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata};
  assign {m_en[1], m_we[1], m_ad[1], m_wd[1]} = {b2.mem_en, b2.mem_we, b2.mem_addr, b2.mem_wdata};
  assign {m_en[2], m_we[2], m_ad[2], m_wd[2]} = {b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata};
  assign b1.mem_rdata = pip[0][0];
  assign b2.mem_rdata = pip[1][1];
  assign b3.mem_rdata = pip[2][2];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_en[i] && m_we[i]) ram[i][m_ad[i]] <= m_wd[i];
      pip[i][0] <= ram[i][m_ad[i]];
      for (int k = 1; k < 4; k++) pip[i][k] <= pip[i][k-1];
    end
  end

  typedef struct {
    logic       bd, br, cr, cw;
    logic [7:0] ca, cwd;
    logic       lr, lw;
    logic [7:0] la, lwd;
    logic       gc, gl, en, we;
    logic [7:0] ma;
    logic       run, cv, lv;
    logic [7:0] rd;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {bd, br, c_req, c_we, l_req, l_we} = '0;
    {c_addr, c_wd, l_addr, l_wd} = '0;
  endtask

  initial begin
    //        bd br cr cw ca     cwd    lr lw la     lwd    gc gl en we ma     run cv lv rd
    vt[0]  = '{0, 0, 1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'hA5, 0, 1, 1, 1, 8'h10, 0, 0, 0, 8'h00};
    vt[1]  = '{0, 0, 1, 0, 8'h10, 8'h00, 1, 1, 8'h11, 8'h5A, 0, 1, 1, 1, 8'h11, 0, 0, 0, 8'h00};
    vt[2]  = '{1, 0, 1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'h77, 0, 1, 1, 1, 8'h20, 0, 0, 0, 8'h00};
    vt[3]  = '{0, 0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h10, 1, 0, 0, 8'h00};
    vt[4]  = '{0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h11, 8'h00, 0, 1, 1, 0, 8'h11, 1, 1, 0, 8'hA5};
    vt[5]  = '{0, 0, 1, 0, 8'h11, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 1, 0, 8'h11, 1, 0, 1, 8'h5A};
    vt[6]  = '{0, 0, 1, 0, 8'h11, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 1, 0, 8'h10, 1, 1, 0, 8'h5A};
    vt[7]  = '{0, 0, 1, 0, 8'h11, 8'h00, 1, 0, 8'h10, 8'h00, 1, 0, 1, 0, 8'h11, 1, 0, 1, 8'hA5};
    vt[8]  = '{0, 0, 1, 0, 8'h11, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 1, 0, 8'h10, 1, 1, 0, 8'h5A};
    vt[9]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hA5};
    vt[10] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00};
    vt[11] = '{0, 0, 1, 1, 8'h30, 8'h3C, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1, 8'h30, 1, 0, 0, 8'h00};
    vt[12] = '{0, 0, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h30, 1, 0, 0, 8'h00};
    vt[13] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h3C};
    idle();
    rst_n = 1'b0; c_req = 1'b1; l_req = 1'b1; l_we = 1'b1; c_addr = 8'h10; l_addr = 8'h10; l_wd = 8'hA5;
    tick(); tick(); #1;
    chk("rst cpu_gnt", b1.cpu_gnt, 0);
    chk("rst ldr_gnt", b1.ldr_gnt, 0);
    chk("rst mem_en", b1.mem_en, 0);
    chk("rst mem_we", b1.mem_we, 0);
    chk("rst cpu_run", run1, 0);
    chk("rst rvalid", {b1.cpu_rvalid, b1.ldr_rvalid, b3.ldr_gnt}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      {bd, br, c_req, c_we, c_addr, c_wd} = {vt[i].bd, vt[i].br, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cwd};
      {l_req, l_we, l_addr, l_wd} = {vt[i].lr, vt[i].lw, vt[i].la, vt[i].lwd};
      #1;
      chk($sformatf("v%0d cpu_gnt", i), b1.cpu_gnt, vt[i].gc);
      chk($sformatf("v%0d ldr_gnt", i), b1.ldr_gnt, vt[i].gl);
      chk($sformatf("v%0d mem_en", i), b1.mem_en, vt[i].en);
      chk($sformatf("v%0d mem_we", i), b1.mem_we, vt[i].we);
      chk($sformatf("v%0d mem_addr", i), b1.mem_addr, vt[i].ma);
      chk($sformatf("v%0d cpu_run", i), run1, vt[i].run);
      chk($sformatf("v%0d cpu_rvalid", i), b1.cpu_rvalid, vt[i].cv);
      chk($sformatf("v%0d ldr_rvalid", i), b1.ldr_rvalid, vt[i].lv);
      if (vt[i].cv) chk($sformatf("v%0d cpu_rdata", i), b1.cpu_rdata, vt[i].rd);
      if (vt[i].lv) chk($sformatf("v%0d ldr_rdata", i), b1.ldr_rdata, vt[i].rd);
      tick();
    end
    // back-to-back CPU then loader reads at RD_LAT=3
    idle();
    repeat (4) tick();
    c_req = 1'b1; c_addr = 8'h10;
    #1 chk("t4 cpu_gnt", b3.cpu_gnt, 1);
    tick();
    c_req = 1'b0; l_req = 1'b1; l_addr = 8'h11;
    #1 chk("t4 ldr_gnt", b3.ldr_gnt, 1);
    chk("t4 c1 cpu_rvalid", b3.cpu_rvalid, 0);
    tick();
    idle();
    #1 chk("t4 c2 cpu_rvalid", b3.cpu_rvalid, 0);
    tick();
    #1 chk("t4 c3 cpu_rvalid", b3.cpu_rvalid, 1);
    chk("t4 c3 cpu_rdata", b3.cpu_rdata, 8'hA5);
    chk("t4 c3 ldr_rvalid", b3.ldr_rvalid, 0);
    tick();
    #1 chk("t4 c4 ldr_rvalid", b3.ldr_rvalid, 1);
    chk("t4 c4 ldr_rdata", b3.ldr_rdata, 8'h5A);
    chk("t4 c4 cpu_rvalid", b3.cpu_rvalid, 0);
    tick();
    #1 chk("t4 c5 ldr_rvalid", b3.ldr_rvalid, 0);
    tick();
    // read in flight while draining back to BOOT at RD_LAT=3
    c_req = 1'b1; c_addr = 8'h10;
    #1 chk("t5 cpu_gnt", b3.cpu_gnt, 1);
    tick();
    c_req = 1'b0; br = 1'b1;
    #1 chk("t5 c1 cpu_run", run3, 1);
    tick();
    br = 1'b0; c_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 8'h40; l_wd = 8'h11;
    #1 chk("t5 c2 cpu_run", run3, 0);
    chk("t5 c2 gnts", {b3.cpu_gnt, b3.ldr_gnt}, 0);
    tick();
    #1 chk("t5 c3 cpu_rvalid", b3.cpu_rvalid, 1);
    chk("t5 c3 cpu_rdata", b3.cpu_rdata, 8'hA5);
    chk("t5 c3 gnts", {b3.cpu_gnt, b3.ldr_gnt}, 0);
    tick();
    #1 chk("t5 c4 cpu_rvalid", b3.cpu_rvalid, 0);
    chk("t5 c4 gnts", {b3.cpu_gnt, b3.ldr_gnt}, 0);
    chk("t5 c4 cpu_run", run3, 0);
    tick();
    #1 chk("t5 c5 ldr_gnt", b3.ldr_gnt, 1);
    chk("t5 c5 cpu_gnt", b3.cpu_gnt, 0);
    chk("t5 c5 mem_we", b3.mem_we, 1);
    chk("t5 c5 cpu_run", run3, 0);
    tick();
    l_req = 1'b0;
    #1 chk("t5 c6 cpu_gnt", b3.cpu_gnt, 0);
    tick();
    // reset one cycle after a CPU read grant at RD_LAT=2
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1; bd = 1'b1;
    tick();
    bd = 1'b0; c_req = 1'b1; c_addr = 8'h10;
    #1 chk("t6 cpu_gnt", b2.cpu_gnt, 1);
    chk("t6 cpu_run", run2, 1);
    tick();
    c_req = 1'b0; rst_n = 1'b0;
    #1 chk("t6 rst cpu_run", run2, 0);
    chk("t6 rst cpu_rvalid", b2.cpu_rvalid, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 2) begin
        rst_n = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 8'h50;
      end
      #1 chk($sformatf("t6 k%0d cpu_rvalid", k), b2.cpu_rvalid, 0);
      chk($sformatf("t6 k%0d ldr_gnt", k), b2.ldr_gnt, (k >= 2) ? 1'b1 : 1'b0);
      chk($sformatf("t6 k%0d cpu_run", k), run2, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
